// File: rtl/axi4_lite_pkg.sv
// Shared types and response codes for the AXI4-Lite register file.
// Optional macro AXIL_REGFILE_ERR_RESP_EN is consumed by axi4_lite_regfile.
package axi4_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RESP_OKAY   = OKAY,
    RESP_SLVERR = SLVERR
  } resp_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  function automatic resp_e range_resp(input logic in_range, input logic err_en);
    return (err_en && !in_range) ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_array.sv
// Byte-enabled register storage: one synchronous write port, one combinational read port.
module axi4_lite_reg_array
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) regs_d[waddr][b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read sees the pre-edge contents, so a same-edge read returns the old value.
  assign rdata = regs_q[raddr];

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register file with independent write and read FSMs.
// Define AXIL_REGFILE_ERR_RESP_EN to answer out-of-range accesses with SLVERR instead of wrapping.
//
// state  | meaning
// W_IDLE | collecting AW and W beats (either order); commit when both held
// W_RESP | BVALID asserted, waiting for BREADY
// R_IDLE | ARREADY high, waiting for an AR beat
// R_DATA | RVALID asserted, RDATA/RRESP held until RREADY
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDRESS-1:0]      S_AWADDR,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ADDRESS-1:0]      S_ARADDR,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  input  logic                    S_RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [ADDRESS-1:0] ADDR_LIMIT = ADDRESS'(NUM_REGS * STRB_W);
`ifdef AXIL_REGFILE_ERR_RESP_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  wstate_e               wstate_q, wstate_d;
  logic                  aw_cap_q, aw_cap_d;
  logic                  w_cap_q, w_cap_d;
  logic [ADDRESS-1:0]    awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  resp_e                 bresp_q, bresp_d;

  rstate_e               rstate_q, rstate_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_e                 rresp_q, rresp_d;

  logic                  aw_hs, w_hs, have_aw, have_w, commit, ar_hs;
  logic [ADDRESS-1:0]    wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_in_range, rd_in_range, arr_we;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign aw_hs   = S_AWVALID && awready_q;
  assign w_hs    = S_WVALID && wready_q;
  assign have_aw = aw_cap_q || aw_hs;
  assign have_w  = w_cap_q || w_hs;
  assign commit  = (wstate_q == W_IDLE) && have_aw && have_w;
  assign ar_hs   = S_ARVALID && arready_q;

  // A beat handshaking this cycle takes precedence over an empty capture register.
  assign wr_addr = aw_cap_q ? awaddr_q : S_AWADDR;
  assign wr_data = w_cap_q ? wdata_q : S_WDATA;
  assign wr_strb = w_cap_q ? wstrb_q : S_WSTRB;

  assign wr_in_range = wr_addr < ADDR_LIMIT;
  assign rd_in_range = S_ARADDR < ADDR_LIMIT;
  assign arr_we      = commit && (wr_in_range || !ERR_EN);

  axi4_lite_reg_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_reg_array (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .we    (arr_we),
    .waddr (wr_addr[OFF_W +: IDX_W]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .raddr (S_ARADDR[OFF_W +: IDX_W]),
    .rdata (arr_rdata)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q  <= W_IDLE;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      aw_cap_q  <= aw_cap_d;
      w_cap_q   <= w_cap_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (commit) wstate_d = W_RESP;
      W_RESP:  if (S_BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    aw_cap_d  = aw_cap_q;
    w_cap_d   = w_cap_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        if (commit) begin
          aw_cap_d  = 1'b0;
          w_cap_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = range_resp(wr_in_range, ERR_EN);
        end else begin
          aw_cap_d  = have_aw;
          w_cap_d   = have_w;
          awready_d = !have_aw;
          wready_d  = !have_w;
          if (aw_hs) awaddr_d = S_AWADDR;
          if (w_hs) begin
            wdata_d = S_WDATA;
            wstrb_d = S_WSTRB;
          end
        end
      end
      W_RESP: begin
        if (S_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ar_hs) rstate_d = R_DATA;
      R_DATA:  if (S_RREADY) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = !ar_hs;
        if (ar_hs) begin
          rvalid_d = 1'b1;
          rresp_d  = range_resp(rd_in_range, ERR_EN);
          rdata_d  = (ERR_EN && !rd_in_range) ? '0 : arr_rdata;
        end
      end
      R_DATA: begin
        if (S_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign S_AWREADY = awready_q;
  assign S_WREADY  = wready_q;
  assign S_BVALID  = bvalid_q;
  assign S_BRESP   = bresp_q;
  assign S_ARREADY = arready_q;
  assign S_RVALID  = rvalid_q;
  assign S_RDATA   = rdata_q;
  assign S_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Scoreboard bench for axi4_lite_regfile: drivers push expected B/R responses from an
// array model, a negedge monitor pops and compares at each B/R handshake.
module tb_axi4_lite_regfile;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 32;
`ifdef AXIL_REGFILE_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          ACLK, ARESETN;
  logic [AW-1:0] S_AWADDR, S_ARADDR;
  logic          S_AWVALID, S_AWREADY, S_WVALID, S_WREADY;
  logic [DW-1:0] S_WDATA, S_RDATA;
  logic [3:0]    S_WSTRB;
  logic [1:0]    S_BRESP, S_RRESP;
  logic          S_BVALID, S_BREADY, S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;

  axi4_lite_regfile #(.ADDRESS(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [NR];
  logic [1:0]  bq [$];
  rexp_t       rq [$];
  rexp_t       mon_re;
  logic [1:0]  mon_be;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return a < NR * 4;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % NR);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (ERR_EN && !in_rng(a)) begin
      bq.push_back(2'b10);
    end else begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[idx_of(a)][b*8 +: 8] = d[b*8 +: 8];
      bq.push_back(2'b00);
    end
  endfunction

  function automatic void model_read(input logic [31:0] a);
    rexp_t e;
    if (ERR_EN && !in_rng(a)) begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end else begin
      e.data = model[idx_of(a)];
      e.resp = 2'b00;
    end
    rq.push_back(e);
  endfunction

  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (S_BVALID && S_BREADY) begin
        if (bq.size() == 0) check("b_unexpected", 1, 0);
        else begin
          mon_be = bq.pop_front();
          check("bresp", S_BRESP, mon_be);
        end
      end
      if (S_RVALID && S_RREADY) begin
        if (rq.size() == 0) check("r_unexpected", 1, 0);
        else begin
          mon_re = rq.pop_front();
          check("rdata", S_RDATA, mon_re.data);
          check("rresp", S_RRESP, mon_re.resp);
        end
      end
    end
  end

  task automatic wait_b(input int bdly, input bit stall);
    bit got = 0;
    logic [1:0] eb;
    S_BREADY = 1'b0;
    for (int i = 0; i < bdly; i++) begin
      if (stall) begin
        S_AWVALID = 1'b1;
        S_AWADDR  = 32'h20;
      end
      @(negedge ACLK);
      if (stall) begin
        eb = (bq.size() > 0) ? bq[0] : 2'b11;
        check("stall_bvalid", S_BVALID, 1);
        check("stall_bresp", S_BRESP, eb);
        check("stall_awready", S_AWREADY, 0);
        check("stall_wready", S_WREADY, 0);
      end
      @(posedge ACLK); #1;
    end
    S_AWVALID = 1'b0;
    S_BREADY  = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge ACLK);
      got = S_BVALID;
      @(posedge ACLK); #1;
    end
    S_BREADY = 1'b0;
    check("b_hs", got, 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int aw_at, input int w_at, input int bdly, input bit stall);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    model_write(a, d, s);
    for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
      if (!aw_done && cyc >= aw_at) begin S_AWVALID = 1'b1; S_AWADDR = a; end
      if (!w_done && cyc >= w_at) begin S_WVALID = 1'b1; S_WDATA = d; S_WSTRB = s; end
      @(negedge ACLK);
      hs_aw = S_AWVALID && S_AWREADY;
      hs_w  = S_WVALID && S_WREADY;
      @(posedge ACLK); #1;
      if (hs_aw) begin aw_done = 1; S_AWVALID = 1'b0; end
      if (hs_w)  begin w_done = 1;  S_WVALID = 1'b0; end
    end
    S_AWVALID = 1'b0;
    S_WVALID  = 1'b0;
    check("wr_hs", {aw_done, w_done}, 2'b11);
    wait_b(bdly, stall);
  endtask

  task automatic rd(input logic [31:0] a, input int rdly);
    bit hs = 0, got = 0;
    model_read(a);
    S_ARVALID = 1'b1;
    S_ARADDR  = a;
    for (int i = 0; i < 40 && !hs; i++) begin
      @(negedge ACLK);
      hs = S_ARREADY;
      @(posedge ACLK); #1;
    end
    S_ARVALID = 1'b0;
    check("ar_hs", hs, 1);
    repeat (rdly) begin @(posedge ACLK); #1; end
    S_RREADY = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge ACLK);
      got = S_RVALID;
      @(posedge ACLK); #1;
    end
    S_RREADY = 1'b0;
    check("r_hs", got, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0;
    S_AWADDR = '0; S_AWVALID = 0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 0; S_BREADY = 0;
    S_ARADDR = '0; S_ARVALID = 0; S_RREADY = 0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;

    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", S_AWREADY, 0);
    check("rst_wready", S_WREADY, 0);
    check("rst_arready", S_ARREADY, 0);
    check("rst_bvalid", S_BVALID, 0);
    check("rst_rvalid", S_RVALID, 0);
    check("rst_bresp", S_BRESP, 0);
    check("rst_rresp", S_RRESP, 0);
    check("rst_rdata", S_RDATA, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    check("rel_awready_pre", S_AWREADY, 0);
    @(posedge ACLK); #1;
    check("rel_awready", S_AWREADY, 1);
    check("rel_wready", S_WREADY, 1);
    check("rel_arready", S_ARREADY, 1);

    // AW leads W by three cycles
    wr(32'h08, 32'hDEADBEEF, 4'hF, 0, 3, 0, 0);
    rd(32'h08, 0);
    // W leads AW, partial strobe
    wr(32'h0C, 32'h11223344, 4'hF, 0, 0, 0, 0);
    wr(32'h0C, 32'h0000CAFE, 4'h3, 2, 0, 1, 0);
    rd(32'h0C, 2);
    // all-zero strobe leaves the register alone
    wr(32'h0C, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0);
    rd(32'h0C, 0);
    // BREADY stalled five cycles with a competing AW beat
    wr(32'h10, 32'hA5A5A5A5, 4'hF, 1, 1, 5, 1);
    rd(32'h10, 0);
    rd(32'h20, 0);

    // read and commit to 0x04 on the same edge
    wr(32'h04, 32'h1, 4'hF, 0, 0, 0, 0);
    model_read(32'h04);
    model_write(32'h04, 32'h2, 4'hF);
    S_AWVALID = 1; S_AWADDR = 32'h04; S_WVALID = 1; S_WDATA = 32'h2; S_WSTRB = 4'hF;
    S_ARVALID = 1; S_ARADDR = 32'h04;
    @(negedge ACLK);
    check("same_edge_readies", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b111);
    @(posedge ACLK); #1;
    S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0;
    S_BREADY = 1; S_RREADY = 1;
    repeat (3) begin @(posedge ACLK); #1; end
    S_BREADY = 0; S_RREADY = 0;
    check("same_edge_drained", bq.size() + rq.size(), 0);
    rd(32'h04, 0);

    // out-of-range access (wraps by default, SLVERR when the error option is built in)
    wr(32'h80, 32'h55, 4'hF, 0, 0, 0, 0);
    rd(32'h80, 0);
    for (int i = 0; i < NR; i++) rd(32'(i * 4), 0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0)
        wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 2), 0);
      else
        rd(a, $urandom_range(0, 2));
    end

    // reset between AW and W must abort the write and clear every register
    S_AWVALID = 1; S_AWADDR = 32'h14;
    @(negedge ACLK);
    check("abort_aw_accept", S_AWREADY, 1);
    @(posedge ACLK); #1;
    S_AWVALID = 0;
    ARESETN = 1'b0;
    #1;
    check("abort_awready", S_AWREADY, 0);
    check("abort_wready", S_WREADY, 0);
    check("abort_arready", S_ARREADY, 0);
    check("abort_bvalid", S_BVALID, 0);
    repeat (2) @(posedge ACLK);
    bq.delete();
    rq.delete();
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    S_WVALID = 1; S_WDATA = 32'hFFFFFFFF; S_WSTRB = 4'hF;
    @(posedge ACLK); #1;
    check("abort_rel_awready", S_AWREADY, 1);
    check("abort_rel_arready", S_ARREADY, 1);
    S_WVALID = 0;
    repeat (3) begin @(posedge ACLK); #1; end
    check("abort_no_bvalid", S_BVALID, 0);
    for (int i = 0; i < NR; i++) rd(32'(i * 4), 0);

    repeat (3) @(posedge ACLK);
    check("queues_empty", bq.size() + rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
